// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button event classifier.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } btn_state_t;

  localparam int unsigned BTN_LONG_CYCLES_DEF   = 5_000_000;
  localparam int unsigned BTN_REPEAT_CYCLES_DEF = 1_000_000;
  localparam int unsigned BTN_CNT_W_DEF         = 24;

endpackage : button_pkg

// File: rtl/button_event_hold_timer.sv
// Hold timer: counts enabled cycles and wraps to 0 when the count reaches limit-1.
module hold_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           en,
  input  logic [CNT_W:0] limit,
  output logic           expire
);

  localparam int unsigned LIM_W = CNT_W + 1;

  logic [CNT_W-1:0] count;

  // Expiry is combinational so the FSM can act on the same edge the count matches.
  assign expire = en && ({1'b0, count} == (limit - LIM_W'(1)));

  // Count register: clear has priority, expiry restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : hold_timer

// File: rtl/button_event.sv
// Button event classifier: turns the debounced level into press/short/long/repeat pulses.
// Optional auto-repeat in the long-held state is enabled by defining BTN_EVENT_REPEAT_EN.
module button_event
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = BTN_LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = BTN_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned LIM_W = CNT_W + 1;

  btn_state_t       state, state_d;
  logic             prev;
  logic             press_d, short_d, long_d;
  logic             tmr_clear, tmr_en, tmr_expire;
  logic [LIM_W-1:0] tmr_limit;

  // Timer restarts on an accepted press; it runs while held in the timed states.
  assign tmr_clear = (state == ST_IDLE) && btn_level && !prev;
`ifdef BTN_EVENT_REPEAT_EN
  assign tmr_en    = btn_level && ((state == ST_PRESSED) || (state == ST_LONG_HELD));
`else
  assign tmr_en    = btn_level && (state == ST_PRESSED);
`endif
  assign tmr_limit = (state == ST_PRESSED) ? LIM_W'(LONG_CYCLES) : LIM_W'(REPEAT_CYCLES);

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .limit  (tmr_limit),
    .expire (tmr_expire)
  );

`ifdef BTN_EVENT_REPEAT_EN
  logic repeat_d;
`endif

  // Next-state and pulse decode; release is checked before the threshold so it wins.
  always_comb begin
    state_d = state;
    press_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
    repeat_d = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (btn_level && !prev) begin
          press_d = 1'b1;
          state_d = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (!btn_level) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (!btn_level) begin
          state_d = ST_IDLE;
        end
`ifdef BTN_EVENT_REPEAT_EN
        else if (tmr_expire) begin
          repeat_d = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, last-level and registered outputs; prev resets high so a held button is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      prev        <= 1'b1;
      press_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_d;
      prev        <= btn_level;
      press_pulse <= press_d;
      short_pulse <= short_d;
      long_pulse  <= long_d;
      held        <= (state_d != ST_IDLE);
    end
  end

`ifdef BTN_EVENT_REPEAT_EN
  // Registered auto-repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= repeat_d;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule : button_event

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event;

  localparam int unsigned LONG   = 8;
  localparam int unsigned REPEAT = 4;
`ifdef BTN_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic btn_level;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, held;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected {press, short, long, repeat, held} per clock edge.
  logic [4:0] exp_q[$];

  // Reference model state: whether a press is in progress and how many edges since it.
  bit m_active;
  bit m_prev;
  int m_k;

  button_event #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REPEAT),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model one sampled edge in terms of edges elapsed since the press edge.
  task automatic model_step();
    logic [4:0] e;
    e = '0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_prev   = 1'b1;
    end else begin
      if (!m_active) begin
        if (btn_level && !m_prev) begin
          m_active = 1'b1;
          m_k      = 0;
          e[4]     = 1'b1;
          e[0]     = 1'b1;
        end
      end else begin
        m_k++;
        if (!btn_level) begin
          if (m_k <= int'(LONG)) e[3] = 1'b1;
          m_active = 1'b0;
        end else begin
          e[0] = 1'b1;
          if (m_k == int'(LONG)) e[2] = 1'b1;
          else if (REP_EN && m_k > int'(LONG) && ((m_k - int'(LONG)) % int'(REPEAT)) == 0)
            e[1] = 1'b1;
        end
      end
      m_prev = btn_level;
    end
    exp_q.push_back(e);
  endtask

  // One clock: drive on the falling edge, model the rising edge.
  task automatic cycle(input bit b, input bit r);
    @(negedge clk);
    btn_level = b;
    rst_n     = r;
    @(posedge clk);
    cyc++;
    model_step();
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) cycle(b, 1'b1);
  endtask

  // Monitor: compare the registered outputs against the queued expectation.
  initial begin
    logic [4:0] got, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {press_pulse, short_pulse, long_pulse, repeat_pulse, held};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got(p,s,l,r,h)=%b exp=%b", cyc, got, e);
        end
        checks++;
        if ($countones(got[4:1]) > 1) begin
          failures++;
          $display("FAIL onehot_pulses cyc=%0d got=%b exp=at most one pulse", cyc, got[4:1]);
        end
      end
    end
  end

  initial begin
    logic [4:0] got;
    m_active  = 1'b0;
    m_prev    = 1'b1;
    m_k       = 0;
    rst_n     = 1'b0;
    btn_level = 1'b1;

    // Button held through reset release produces no press; later low-to-high does.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    hold(1'b1, 10);
    hold(1'b0, 2);
    hold(1'b1, 1);
    // Short press: release sampled at E3.
    hold(1'b1, 2);
    hold(1'b0, 3);
    // Release at exactly E8: short wins over long.
    hold(1'b1, 8);
    hold(1'b0, 3);
    // Hold to E19, release at E20: long at E8, repeats at E12 and E16 when enabled.
    hold(1'b1, 20);
    hold(1'b0, 3);
    // Asynchronous reset in LONG_HELD at E10, button still held after release.
    hold(1'b1, 11);
    #7 rst_n = 1'b0;
    #1;
    got = {press_pulse, short_pulse, long_pulse, repeat_pulse, held};
    checks++;
    if (got !== 5'b0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=00000", got);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);
    hold(1'b1, 6);
    hold(1'b0, 1);
    hold(1'b1, 3);
    hold(1'b0, 2);

    // Randomized level segments with occasional mid-run resets.
    for (int s = 0; s < 250; s++) begin
      int unsigned len;
      len = (($urandom % 4) == 0) ? $urandom_range(6, 22) : $urandom_range(1, 5);
      hold(s[0], int'(len));
      if (($urandom % 40) == 0) begin
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
      end
    end
    hold(1'b0, 3);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d exp=finish before limit", cyc);
    $fatal(1, "timeout");
  end

endmodule : tb_button_event
